// File: rtl/rs_alloc_select.sv
// rs_alloc_select: reservation-station entry allocator.
// Tracks which RS entries are occupied, keeps the three lowest free entries
// registered as one-hot candidates, and hands them out to up to three
// dispatch lanes in the same cycle the request arrives.
//
// Request/grant handshake: alloc_req is a level request sampled every
// cycle. The whole group is granted (alloc_ok=1, one-hot alloc_sel* per
// requesting lane) or refused (stall=1, no selects). A refused group leaves
// occupancy untouched apart from frees. The requester keeps presenting it
// until alloc_ok is seen. There is no partial grant.

module rs_alloc_select #(
  parameter int BUF_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 except,
  input  logic [2:0]           alloc_req,
  input  logic [BUF_COUNT-1:0] free_mask,
  output logic [BUF_COUNT-1:0] alloc_sel0,
  output logic [BUF_COUNT-1:0] alloc_sel1,
  output logic [BUF_COUNT-1:0] alloc_sel2,
  output logic                 alloc_ok,
  output logic                 stall,
  output logic [6:0]           free_cnt
);

  localparam logic [BUF_COUNT-1:0] ONE_HOT0 = {{(BUF_COUNT-1){1'b0}}, 1'b1};
  localparam logic [6:0]           CNT_MAX  = 7'(BUF_COUNT);

  // Registered state
  logic [BUF_COUNT-1:0] occ_q, occ_d;
  logic [BUF_COUNT-1:0] cand0_q, cand0_d;
  logic [BUF_COUNT-1:0] cand1_q, cand1_d;
  logic [BUF_COUNT-1:0] cand2_q, cand2_d;
  logic [2:0]           cand_vld_q, cand_vld_d;
  logic [6:0]           free_cnt_q, free_cnt_d;

  // Request decode
  logic [1:0]           nreq;
  logic [1:0]           below_lane2;
  logic                 fits;
  logic                 grant;
  logic [BUF_COUNT-1:0] slot1;
  logic [BUF_COUNT-1:0] slot2;
  logic [BUF_COUNT-1:0] grant_or;

  // Candidate search scratch
  logic [1:0]           found;
  logic [6:0]           used_cnt;

  // Count requesting lanes and decide the all-or-nothing grant.
  // rst is folded in so nothing is granted or stalled while in reset.
  always_comb begin
    nreq        = 2'(alloc_req[0]) + 2'(alloc_req[1]) + 2'(alloc_req[2]);
    below_lane2 = 2'(alloc_req[0]) + 2'(alloc_req[1]);
    case (nreq)
      2'd1:    fits = cand_vld_q[0];
      2'd2:    fits = cand_vld_q[1];
      2'd3:    fits = cand_vld_q[2];
      default: fits = 1'b0;
    endcase
    grant = fits && !except && rst;
    stall = (nreq != 2'd0) && !grant && !except && rst;
  end

  // Lane compaction: each requesting lane takes the next unused candidate.
  always_comb begin
    slot1 = alloc_req[0] ? cand1_q : cand0_q;
    case (below_lane2)
      2'd0:    slot2 = cand0_q;
      2'd1:    slot2 = cand1_q;
      default: slot2 = cand2_q;
    endcase
    alloc_sel0 = (grant && alloc_req[0]) ? cand0_q : '0;
    alloc_sel1 = (grant && alloc_req[1]) ? slot1   : '0;
    alloc_sel2 = (grant && alloc_req[2]) ? slot2   : '0;
    alloc_ok   = grant;
    grant_or   = alloc_sel0 | alloc_sel1 | alloc_sel2;
  end

  // Next occupancy: flush clears everything; otherwise frees apply first and
  // grants are OR'd in afterwards so a grant wins over a same-cycle free.
  always_comb begin
    if (except) begin
      occ_d = '0;
    end else begin
      occ_d = (occ_q & ~free_mask) | grant_or;
    end
  end

  // Find the three lowest free entries of the next occupancy and count the
  // occupied ones, so next cycle's candidates reflect this cycle's frees.
  always_comb begin
    cand0_d  = '0;
    cand1_d  = '0;
    cand2_d  = '0;
    found    = 2'd0;
    used_cnt = 7'd0;
    for (int i = 0; i < BUF_COUNT; i++) begin
      if (occ_d[i]) begin
        used_cnt = used_cnt + 7'd1;
      end else begin
        case (found)
          2'd0:    cand0_d[i] = 1'b1;
          2'd1:    cand1_d[i] = 1'b1;
          2'd2:    cand2_d[i] = 1'b1;
          default: ;
        endcase
        if (found != 2'd3) found = found + 2'd1;
      end
    end
    cand_vld_d = {found == 2'd3, found >= 2'd2, found != 2'd0};
    free_cnt_d = CNT_MAX - used_cnt;
  end

  // State registers; reset leaves entries 0,1,2 as the first candidates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      cand0_q    <= ONE_HOT0;
      cand1_q    <= ONE_HOT0 << 1;
      cand2_q    <= ONE_HOT0 << 2;
      cand_vld_q <= 3'b111;
      free_cnt_q <= CNT_MAX;
    end else begin
      occ_q      <= occ_d;
      cand0_q    <= cand0_d;
      cand1_q    <= cand1_d;
      cand2_q    <= cand2_d;
      cand_vld_q <= cand_vld_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign free_cnt = free_cnt_q;

  // Granted entries are always free and never shared between lanes.
  a_grant_free: assert property (@(posedge clk) disable iff (!rst)
    (grant_or & occ_q) == '0);
  a_grant_disjoint: assert property (@(posedge clk) disable iff (!rst)
    ((alloc_sel0 & alloc_sel1) | (alloc_sel0 & alloc_sel2) |
     (alloc_sel1 & alloc_sel2)) == '0);

endmodule

// File: tb/tb_rs_alloc_select.sv
// Bench for rs_alloc_select at BUF_COUNT 32 and 48. One instance is
// driven at a time; the other idles. Expected values come from a reference
// model that keeps occupancy as a bit array and grants from an ascending
// list of free indices.

module tb_rs_alloc_select;

  // Clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus, routed to whichever instance is active
  logic        use48;
  logic        ex;
  logic [2:0]  req;
  logic [47:0] fm;

  logic        ex32, ex48;
  logic [2:0]  req32, req48;
  logic [31:0] fm32;
  logic [47:0] fm48;
  assign ex32  = use48 ? 1'b0 : ex;
  assign ex48  = use48 ? ex : 1'b0;
  assign req32 = use48 ? 3'b000 : req;
  assign req48 = use48 ? req : 3'b000;
  assign fm32  = use48 ? 32'h0 : fm[31:0];
  assign fm48  = use48 ? fm : 48'h0;

  logic [31:0] a_sel0, a_sel1, a_sel2;
  logic        a_ok, a_stall;
  logic [6:0]  a_cnt;
  logic [47:0] b_sel0, b_sel1, b_sel2;
  logic        b_ok, b_stall;
  logic [6:0]  b_cnt;

  rs_alloc_select #(.BUF_COUNT(32)) dut32 (
    .clk(clk), .rst(rst), .except(ex32), .alloc_req(req32), .free_mask(fm32),
    .alloc_sel0(a_sel0), .alloc_sel1(a_sel1), .alloc_sel2(a_sel2),
    .alloc_ok(a_ok), .stall(a_stall), .free_cnt(a_cnt)
  );

  rs_alloc_select #(.BUF_COUNT(48)) dut48 (
    .clk(clk), .rst(rst), .except(ex48), .alloc_req(req48), .free_mask(fm48),
    .alloc_sel0(b_sel0), .alloc_sel1(b_sel1), .alloc_sel2(b_sel2),
    .alloc_ok(b_ok), .stall(b_stall), .free_cnt(b_cnt)
  );

  logic [47:0] o_sel0, o_sel1, o_sel2;
  logic        o_ok, o_stall;
  logic [6:0]  o_cnt;
  assign o_sel0  = use48 ? b_sel0 : {16'h0, a_sel0};
  assign o_sel1  = use48 ? b_sel1 : {16'h0, a_sel1};
  assign o_sel2  = use48 ? b_sel2 : {16'h0, a_sel2};
  assign o_ok    = use48 ? b_ok : a_ok;
  assign o_stall = use48 ? b_stall : a_stall;
  assign o_cnt   = use48 ? b_cnt : a_cnt;

  // Scoreboard state
  int          n_checks;
  int          n_err;
  int          bc;
  bit          occ[48];
  logic [47:0] mask;
  logic [47:0] one48;
  logic [47:0] last_sel0, last_sel1, last_sel2;
  logic        last_ok, last_stall;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (bc=%0d): got %0h expected %0h", tag, bc, got, exp);
    end
  endtask

  function automatic int model_free();
    int n;
    n = 0;
    for (int i = 0; i < bc; i++) if (!occ[i]) n++;
    return n;
  endfunction

  // One clock of stimulus: predict, compare at negedge, update model.
  task automatic cycle(input logic [2:0] r, input logic [47:0] f, input logic e);
    int fl[$];
    int nr;
    int j;
    logic eok, est;
    logic [47:0] es[3];
    req = r;
    fm  = f & mask;
    ex  = e;
    fl = {};
    for (int i = 0; i < bc; i++) if (!occ[i]) fl.push_back(i);
    nr  = int'(r[0]) + int'(r[1]) + int'(r[2]);
    eok = (nr > 0) && (fl.size() >= nr) && !e;
    est = (nr > 0) && !eok && !e;
    j = 0;
    exp_q = {};
    for (int k = 0; k < 3; k++) begin
      es[k] = '0;
      if (r[k]) begin
        if (eok) es[k] = one48 << fl[j];
        j++;
      end
      exp_q.push_back(es[k]);
    end
    @(negedge clk);
    last_sel0  = o_sel0;
    last_sel1  = o_sel1;
    last_sel2  = o_sel2;
    last_ok    = o_ok;
    last_stall = o_stall;
    check("sel0", o_sel0, exp_q.pop_front());
    check("sel1", o_sel1, exp_q.pop_front());
    check("sel2", o_sel2, exp_q.pop_front());
    check("alloc_ok", {47'h0, o_ok}, {47'h0, eok});
    check("stall", {47'h0, o_stall}, {47'h0, est});
    check("free_cnt", {41'h0, o_cnt}, 48'(fl.size()));
    @(posedge clk);
    if (e) begin
      for (int i = 0; i < 48; i++) occ[i] = 1'b0;
    end else begin
      for (int i = 0; i < bc; i++) if (fm[i]) occ[i] = 1'b0;
      j = 0;
      for (int k = 0; k < 3; k++) begin
        if (r[k]) begin
          if (eok) occ[fl[j]] = 1'b1;
          j++;
        end
      end
    end
    #1;
  endtask

  // Asynchronous reset mid-cycle with a full request pending.
  task automatic do_reset();
    req = 3'b111;
    fm  = '0;
    ex  = 1'b0;
    #1;
    rst = 1'b0;
    #2;
    check("rst_sel0", o_sel0, 48'h0);
    check("rst_sel1", o_sel1, 48'h0);
    check("rst_sel2", o_sel2, 48'h0);
    check("rst_ok", {47'h0, o_ok}, 48'h0);
    check("rst_stall", {47'h0, o_stall}, 48'h0);
    check("rst_cnt", {41'h0, o_cnt}, 48'(bc));
    for (int i = 0; i < 48; i++) occ[i] = 1'b0;
    req = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_size(input logic big);
    int nf;
    logic [2:0]  r;
    logic [47:0] f;
    int div;
    use48 = big;
    bc    = big ? 48 : 32;
    mask  = big ? 48'hFFFF_FFFF_FFFF : 48'h0000_FFFF_FFFF;
    @(posedge clk);
    #1;
    do_reset();

    // First group of three after reset takes entries 0,1,2
    cycle(3'b111, '0, 1'b0);
    check("d1_sel0", last_sel0, 48'h1);
    check("d1_sel1", last_sel1, 48'h2);
    check("d1_sel2", last_sel2, 48'h4);
    check("d1_ok", {47'h0, last_ok}, 48'h1);
    check("d1_cnt", {41'h0, o_cnt}, 48'(bc - 3));

    // Lanes 0 and 2 compact onto candidates 3 and 4
    cycle(3'b101, '0, 1'b0);
    check("d2_sel0", last_sel0, 48'h8);
    check("d2_sel1", last_sel1, 48'h0);
    check("d2_sel2", last_sel2, 48'h10);
    check("d2_cnt", {41'h0, o_cnt}, 48'(bc - 5));

    // Fill to two free, then a group of three is refused, two is granted
    nf = model_free();
    while (nf > 2) begin
      if (nf - 2 >= 3)      cycle(3'b111, '0, 1'b0);
      else if (nf - 2 == 2) cycle(3'b011, '0, 1'b0);
      else                  cycle(3'b001, '0, 1'b0);
      nf = model_free();
    end
    cycle(3'b111, '0, 1'b0);
    check("d3_stall", {47'h0, last_stall}, 48'h1);
    check("d3_ok", {47'h0, last_ok}, 48'h0);
    check("d3_sels", last_sel0 | last_sel1 | last_sel2, 48'h0);
    check("d3_cnt", {41'h0, o_cnt}, 48'h2);
    cycle(3'b011, '0, 1'b0);
    check("d3_ok2", {47'h0, last_ok}, 48'h1);
    check("d3_cnt2", {41'h0, o_cnt}, 48'h0);

    // Entry freed while full becomes allocatable only the next cycle
    cycle(3'b001, 48'h80, 1'b0);
    check("d4_stall", {47'h0, last_stall}, 48'h1);
    cycle(3'b001, '0, 1'b0);
    check("d4_sel0", last_sel0, 48'h80);
    check("d4_ok", {47'h0, last_ok}, 48'h1);

    // Flush beats a pending request and frees
    cycle(3'b111, 48'h0F0, 1'b1);
    check("d5_ok", {47'h0, last_ok}, 48'h0);
    check("d5_stall", {47'h0, last_stall}, 48'h0);
    check("d5_sels", last_sel0 | last_sel1 | last_sel2, 48'h0);
    check("d5_cnt", {41'h0, o_cnt}, 48'(bc));
    cycle(3'b111, '0, 1'b0);
    check("d5_sel0", last_sel0, 48'h1);
    check("d5_sel1", last_sel1, 48'h2);
    check("d5_sel2", last_sel2, 48'h4);

    // Randomized alloc/free traffic with alternating free pressure
    for (int c = 0; c < 10000; c++) begin
      f   = '0;
      div = ((c / 400) % 2 == 1) ? 20 : 3;
      for (int i = 0; i < bc; i++)
        if (occ[i] && ($urandom_range(div - 1) == 0)) f[i] = 1'b1;
      if ($urandom_range(15) == 0) f[$urandom_range(bc - 1)] = 1'b1;
      r = 3'($urandom_range(7));
      cycle(r, f, ($urandom_range(299) == 0));
    end

    // Reset in the middle of traffic, then entries 0,1,2 come first again
    cycle(3'b011, '0, 1'b0);
    do_reset();
    cycle(3'b111, '0, 1'b0);
    check("d6_sel0", last_sel0, 48'h1);
    check("d6_sel1", last_sel1, 48'h2);
    check("d6_sel2", last_sel2, 48'h4);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    one48    = 48'h1;
    rst      = 1'b0;
    req      = 3'b000;
    fm       = '0;
    ex       = 1'b0;
    use48    = 1'b0;
    bc       = 32;
    mask     = 48'h0000_FFFF_FFFF;
    repeat (2) @(posedge clk);
    rst = 1'b1;
    run_size(1'b0);
    run_size(1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
